fifo_rd_stream: RTL and testbench

- Read-side consumer for the team's 8-bit gray-pointer async FIFO, living entirely in the read clock domain.
- Converts the FIFO's pop interface (rd_en/empty, data registered one cycle after the pop) into a valid/ready byte stream with full throughput and no byte loss under backpressure.
- Adds fixed-length frame delimiting (m_last) and a transferred-frame counter for downstream packet logic.

---
 rtl/fifo_pkg.sv | 17 +
 rtl/fifo_rd_stream_if.sv | 38 +++
 rtl/fifo_rd_skid.sv | 66 ++++++
 rtl/fifo_rd_stream.sv | 104 ++++++++++
 tb/tb_fifo_rd_stream.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit gray-pointer async FIFO and its read-side consumers.
package fifo_pkg;

  localparam int FIFO_DW       = 8;
  localparam int FRAME_LEN_DEF = 16;
  localparam int CNT_W_DEF     = 16;
  localparam int BUF_DEPTH_DEF = 2;
  // Frame position counter width; covers the full legal FRAME_LEN range.
  localparam int IDX_W         = 16;

  typedef logic [FIFO_DW-1:0] byte_t;

  function automatic logic is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO pop side plus valid/ready byte stream of the read-side consumer.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int DW = FIFO_DW
);

  logic          fifo_rd_en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;

  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_last;

  // master: the consumer block; slave: FIFO plus downstream sink.
  modport master (
    output fifo_rd_en,
    input  fifo_empty,
    input  fifo_rd_data,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last
  );

  modport slave (
    input  fifo_rd_en,
    output fifo_empty,
    output fifo_rd_data,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Small circular output buffer: push from the FIFO read data, pop on stream handshake.
module fifo_rd_skid
  import fifo_pkg::*;
#(
  parameter  int DW    = FIFO_DW,
  parameter  int DEPTH = BUF_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int OW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [OW-1:0] occ,
  output logic          head_valid,
  output logic [DW-1:0] head_data
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_idx;
  logic [AW-1:0] r_rd_idx;
  logic [OW-1:0] r_occ;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order inside the block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_idx <= '0;
      r_rd_idx <= '0;
      r_occ    <= '0;
      // NOTE: the storage is cleared only because it is tiny and the head entry
      // is the visible m_data; a deep buffer would leave its array unreset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (push) begin
        r_mem[r_wr_idx] <= push_data;
        r_wr_idx        <= r_wr_idx + 1'b1;
      end
      if (pop) begin
        r_rd_idx <= r_rd_idx + 1'b1;
      end
      case ({push, pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign occ        = r_occ;
  assign head_valid = (r_occ != '0);
  assign head_data  = r_mem[r_rd_idx];

  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
    r_occ <= OW'(DEPTH));

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (r_occ == OW'(DEPTH))));

  a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(pop && (r_occ == '0)));

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-domain consumer: turns the FIFO pop interface into a framed valid/ready byte stream.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DW        = FIFO_DW,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             enable,
  fifo_rd_stream_if.master bus,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             busy
);

  localparam int OW = $clog2(BUF_DEPTH) + 1;
  localparam int SW = OW + 1;

  if (BUF_DEPTH < 2 || !is_pow2(BUF_DEPTH)) begin : g_bad_depth
    $error("fifo_rd_stream: BUF_DEPTH must be a power of two and at least 2");
  end
  if (FRAME_LEN < 1 || FRAME_LEN > 65535) begin : g_bad_frame
    $error("fifo_rd_stream: FRAME_LEN must lie in 1..65535");
  end

  logic [OW-1:0]    w_occ;
  logic             w_head_valid;
  logic [DW-1:0]    w_head_data;
  logic             w_hs;
  logic             w_last_pos;
  logic             w_rd_en;
  logic [SW-1:0]    w_committed;
  logic [SW-1:0]    w_limit;

  logic             r_pop_d1;
  logic [IDX_W-1:0] r_byte_idx;
  logic [CNT_W-1:0] r_frame_cnt;

  // Pop control: count buffered plus in-flight bytes against the space that
  // will exist after this cycle's handshake, so a full buffer under steady
  // acceptance still pops every cycle.
  always_comb begin
    // NOTE: every always_comb output gets a value before any condition, so
    // no path can leave one unassigned and infer a latch.
    w_hs        = 1'b0;
    w_committed = '0;
    w_limit     = '0;
    w_rd_en     = 1'b0;

    w_hs        = w_head_valid & bus.m_ready;
    w_committed = SW'(w_occ) + SW'(r_pop_d1);
    w_limit     = SW'(BUF_DEPTH) + SW'(w_hs);
    w_rd_en     = rd_rst_n & enable & ~bus.fifo_empty & (w_committed < w_limit);
  end

  assign w_last_pos = (r_byte_idx == IDX_W'(FRAME_LEN - 1));

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      r_pop_d1    <= 1'b0;
      r_byte_idx  <= '0;
      r_frame_cnt <= '0;
    end else begin
      r_pop_d1 <= w_rd_en;
      if (w_hs) begin
        if (w_last_pos) begin
          r_byte_idx  <= '0;
          r_frame_cnt <= r_frame_cnt + 1'b1;
        end else begin
          r_byte_idx  <= r_byte_idx + 1'b1;
        end
      end
    end
  end

  // The FIFO registers its read data, so the byte popped last cycle lands now.
  fifo_rd_skid #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH)
  ) u_skid (
    .clk        (rd_clk),
    .rst_n      (rd_rst_n),
    .push       (r_pop_d1),
    .push_data  (bus.fifo_rd_data),
    .pop        (w_hs),
    .occ        (w_occ),
    .head_valid (w_head_valid),
    .head_data  (w_head_data)
  );

  assign bus.fifo_rd_en = w_rd_en;
  assign bus.m_valid    = w_head_valid;
  assign bus.m_data     = w_head_data;
  assign bus.m_last     = w_head_valid & w_last_pos;
  assign frame_cnt      = r_frame_cnt;
  assign busy           = (w_occ != '0) | r_pop_d1;

  a_hold_under_stall : assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    (bus.m_valid && !bus.m_ready) |=>
      (bus.m_valid && $stable(bus.m_data) && $stable(bus.m_last)));

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: behavioural FIFO models feed two instances (FRAME_LEN 16 and 5).
module tb_fifo_rd_stream;
  import fifo_pkg::*;

  localparam int N_B = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en_a  = 1'b0;
  logic en_b  = 1'b0;
  logic gate_b = 1'b0;

  logic [15:0] fcnt_a, fcnt_b;
  logic        busy_a, busy_b;

  int n_cmp = 0;
  int n_err = 0;

  fifo_rd_stream_if #(.DW(FIFO_DW)) if_a ();
  fifo_rd_stream_if #(.DW(FIFO_DW)) if_b ();

  fifo_rd_stream #(.DW(FIFO_DW), .BUF_DEPTH(2), .FRAME_LEN(16), .CNT_W(16)) u_dut_a (
    .rd_clk    (clk),
    .rd_rst_n  (rst_n),
    .enable    (en_a),
    .bus       (if_a.master),
    .frame_cnt (fcnt_a),
    .busy      (busy_a)
  );

  fifo_rd_stream #(.DW(FIFO_DW), .BUF_DEPTH(2), .FRAME_LEN(5), .CNT_W(16)) u_dut_b (
    .rd_clk    (clk),
    .rd_rst_n  (rst_n),
    .enable    (en_b),
    .bus       (if_b.master),
    .frame_cnt (fcnt_b),
    .busy      (busy_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // FIFO model A: registered read data one cycle after the pop.
  byte_t mem_a [256];
  int    wr_a = 0;
  int    rd_a = 0;
  assign if_a.fifo_empty = (wr_a == rd_a);
  always @(posedge clk) begin
    if (if_a.fifo_rd_en) begin
      if_a.fifo_rd_data <= mem_a[rd_a[7:0]];
      rd_a <= rd_a + 1;
    end
  end

  // FIFO model B with an extra random empty gate.
  byte_t mem_b [16384];
  int    wr_b = 0;
  int    rd_b = 0;
  assign if_b.fifo_empty = (wr_b == rd_b) || gate_b;
  always @(posedge clk) begin
    if (if_b.fifo_rd_en) begin
      if_b.fifo_rd_data <= mem_b[rd_b[13:0]];
      rd_b <= rd_b + 1;
    end
  end

  // Scoreboards: next expected byte is the next one the FIFO handed out after reset.
  int hs_a = 0, exp_a = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_a  = 0;
      exp_a = rd_a;
    end else if (if_a.m_valid && if_a.m_ready) begin
      check("a_data", 32'(if_a.m_data), 32'(mem_a[exp_a[7:0]]));
      check("a_last", 32'(if_a.m_last), 32'((hs_a % 16) == 15));
      exp_a++;
      hs_a++;
    end
  end

  int hs_b = 0, exp_b = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_b  = 0;
      exp_b = rd_b;
    end else if (if_b.m_valid && if_b.m_ready) begin
      check("b_data", 32'(if_b.m_data), 32'(mem_b[exp_b[13:0]]));
      check("b_last", 32'(if_b.m_last), 32'((hs_b % 5) == 4));
      exp_b++;
      hs_b++;
    end
  end

  task automatic load_a(input int n);
    for (int i = 0; i < n; i++) begin
      mem_a[wr_a[7:0]] = byte_t'(wr_a);
      wr_a++;
    end
  endtask

  task automatic drain_a(input string tag);
    for (int k = 0; k < 300 && (busy_a || !if_a.fifo_empty); k++) @(negedge clk);
    check(tag, 32'(busy_a), 32'd0);
  endtask

  int pre_rd;
  int rst_rd;

  initial begin
    en_a = 1'b1;
    if_a.m_ready = 1'b1;
    if_b.m_ready = 1'b0;
    load_a(32);

    // 1. reset with data waiting and enable high
    #2;
    check("rst_rd_en", 32'(if_a.fifo_rd_en), 32'd0);
    check("rst_valid", 32'(if_a.m_valid), 32'd0);
    check("rst_last", 32'(if_a.m_last), 32'd0);
    check("rst_data", 32'(if_a.m_data), 32'd0);
    check("rst_fcnt", 32'(fcnt_a), 32'd0);
    check("rst_busy", 32'(busy_a), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1;
    check("rel_rd_en", 32'(if_a.fifo_rd_en), 32'd1);
    repeat (2) @(negedge clk);
    check("lat_valid_early", 32'(if_a.m_valid), 32'd0);

    // 2. full-rate streaming of 0x00..0x1F
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check("t2_valid", 32'(if_a.m_valid), 32'd1);
    end
    @(negedge clk);
    check("t2_valid_end", 32'(if_a.m_valid), 32'd0);
    check("t2_busy", 32'(busy_a), 32'd0);
    check("t2_bytes", 32'(hs_a), 32'd32);
    check("t2_fcnt", 32'(fcnt_a), 32'd2);

    // 3. backpressure for 10 cycles mid-stream
    load_a(40);
    for (int k = 0; k < 200 && hs_a < 37; k++) @(posedge clk);
    check("t3_reach", 32'(hs_a), 32'd37);
    #1 if_a.m_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t3_valid", 32'(if_a.m_valid), 32'd1);
      check("t3_hold_data", 32'(if_a.m_data), 32'(mem_a[exp_a[7:0]]));
      check("t3_hold_last", 32'(if_a.m_last), 32'((hs_a % 16) == 15));
      check("t3_buffered", 32'((rd_a - exp_a) <= 2), 32'd1);
      if (k > 0) check("t3_no_pop", 32'(if_a.fifo_rd_en), 32'd0);
    end
    @(posedge clk);
    #1 if_a.m_ready = 1'b1;
    drain_a("t3_busy");
    check("t3_bytes", 32'(hs_a), 32'd72);
    check("t3_fcnt", 32'(fcnt_a), 32'd4);

    // 4. enable dropped right after a single pop
    en_a = 1'b0;
    load_a(20);
    @(posedge clk);
    #1 en_a = 1'b1;
    pre_rd = rd_a;
    #1 check("t4_rd_en", 32'(if_a.fifo_rd_en), 32'd1);
    @(posedge clk);
    #1 en_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t4_no_pop", 32'(if_a.fifo_rd_en), 32'd0);
    end
    check("t4_pops", 32'(rd_a - pre_rd), 32'd1);
    check("t4_inflight", 32'(hs_a), 32'd73);
    check("t4_idle", 32'(busy_a), 32'd0);
    en_a = 1'b1;
    drain_a("t4_busy");
    check("t4_bytes", 32'(hs_a), 32'd92);
    check("t4_fcnt", 32'(fcnt_a), 32'd5);

    // 6. asynchronous reset 7 bytes into a frame with a pop in flight
    load_a(40);
    for (int k = 0; k < 200 && hs_a < 103; k++) @(posedge clk);
    check("t6_reach", 32'(hs_a), 32'd103);
    check("t6_fcnt_pre", 32'(fcnt_a), 32'd6);
    check("t6_busy_pre", 32'(busy_a), 32'd1);
    #2 rst_n = 1'b0;
    rst_rd = rd_a;
    #1;
    check("t6_valid", 32'(if_a.m_valid), 32'd0);
    check("t6_last", 32'(if_a.m_last), 32'd0);
    check("t6_data", 32'(if_a.m_data), 32'd0);
    check("t6_busy", 32'(busy_a), 32'd0);
    check("t6_fcnt", 32'(fcnt_a), 32'd0);
    check("t6_rd_en", 32'(if_a.fifo_rd_en), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    for (int k = 0; k < 20 && !if_a.m_valid; k++) @(negedge clk);
    check("t6_restart", 32'(if_a.m_valid), 32'd1);
    check("t6_fcnt_post", 32'(fcnt_a), 32'd0);
    drain_a("t6_busy_end");
    check("t6_bytes", 32'(hs_a), 32'(wr_a - rst_rd));
    check("t6_fcnt_end", 32'(fcnt_a), 32'(hs_a / 16));

    // 5. random m_ready and fifo_empty, 10k bytes, FRAME_LEN 5
    for (int i = 0; i < N_B; i++) begin
      mem_b[i] = byte_t'(i * 37 + 11);
    end
    wr_b = N_B;
    @(posedge clk);
    #1 en_b = 1'b1;
    for (int c = 0; c < 60000 && hs_b < N_B; c++) begin
      @(posedge clk);
      #1;
      gate_b       = ($urandom_range(0, 3) == 0);
      if_b.m_ready = ($urandom_range(0, 3) != 0);
    end
    if_b.m_ready = 1'b0;
    gate_b       = 1'b0;
    @(negedge clk);
    check("t5_bytes", 32'(hs_b), 32'(N_B));
    check("t5_fcnt", 32'(fcnt_b), 32'd2000);
    check("t5_valid_end", 32'(if_b.m_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
